// File: rtl/prog_seq_pkg.sv
// prog_seq_pkg
// Shared types and default constants for the program sequencer.
//   seq_state_t     : sequencer FSM state encoding
//   CW_DEFAULT      : default cycle-count width
//   TIMEOUT_DEFAULT : default watchdog limit (used only with SEQ_TIMEOUT_EN)
package prog_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        START,
        RUN,
        DONE
    } seq_state_t;

    localparam int CW_DEFAULT      = 16;
    localparam int TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/prog_sequencer_if.sv
// prog_sequencer_if
// Handshake bundle between the sequencer and the processor / host.
//   Go, Ack                      : requests into the sequencer
//   DutReset, Start, ProgSel     : processor control
//   CycleCt, CtValid             : per-program cycle count result
//   Busy, AllDone, TimedOut      : sequencer status
// Modports: master = sequencer side, slave = processor/host side.
interface prog_sequencer_if
    import prog_seq_pkg::*;
#(
    parameter int PW = 2,
    parameter int CW = CW_DEFAULT
);
    logic          Go;
    logic          Ack;
    logic          DutReset;
    logic          Start;
    logic [PW-1:0] ProgSel;
    logic [CW-1:0] CycleCt;
    logic          CtValid;
    logic          Busy;
    logic          AllDone;
    logic          TimedOut;

    modport master (
        input  Go, Ack,
        output DutReset, Start, ProgSel, CycleCt, CtValid, Busy, AllDone, TimedOut
    );

    modport slave (
        output Go, Ack,
        input  DutReset, Start, ProgSel, CycleCt, CtValid, Busy, AllDone, TimedOut
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter with synchronous clear, enable and saturation at all-ones.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable
//   limit      : terminal-count compare value
//   count      : current value
//   tc         : high while count == limit
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] count,
    output logic          tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && (count != '1))
            count <= count + CW'(1);
    end

    assign tc = (count == limit);

endmodule

// File: rtl/prog_sequencer.sv
// prog_sequencer
// Runs programs 0..NUM_PROGS-1 back to back on the processor: holds it in
// reset while idle, pulses Start for START_CYCLES per program, waits for Ack
// and reports each program's RUN cycle count.
//   Clk    : clock, posedge
//   Reset  : asynchronous active-low reset
//   io     : prog_sequencer_if.master (Go/Ack in; control and status out)
// Optional feature macro: SEQ_TIMEOUT_EN enables the RUN watchdog
// (TIMEOUT_CYCLES); without it TimedOut is tied low.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int NUM_PROGS      = 3,
    parameter int PW             = 2,
    parameter int START_CYCLES   = 2,
    parameter int CW             = CW_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    prog_sequencer_if.master  io
);

    localparam logic [PW-1:0] LAST_PROG  = PW'(NUM_PROGS - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
`ifdef SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] RUN_LIMIT  = CW'(TIMEOUT_CYCLES - 1);
`else
    localparam logic [CW-1:0] RUN_LIMIT  = '1;
`endif

    generate
        if (NUM_PROGS < 1 || NUM_PROGS > (1 << PW) || START_CYCLES < 1 ||
            TIMEOUT_CYCLES <= 1) begin : g_bad_params
            $error("prog_sequencer: parameter out of range");
        end
    endgenerate

    seq_state_t    state;
    logic [CW-1:0] count;
    logic [CW-1:0] limit;
    logic          tc;
    logic          cnt_clr;
    logic          cnt_en;
    logic          wd_rst;   // one-cycle DutReset pulse after a watchdog abort

    // One counter serves both the START window and the RUN count; it is
    // cleared on every transition into START or RUN so each phase begins at 0.
    assign limit   = (state == START) ? START_LAST : RUN_LIMIT;
    assign cnt_clr = !(state inside {START, RUN}) ||
                     (state == START && tc) ||
                     (state == RUN && io.Ack);
    assign cnt_en  = (state == START) || (state == RUN && !io.Ack);

    sat_counter #(.CW(CW)) u_cnt (
        .clk   (Clk),
        .rst_n (Reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .limit (limit),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            io.ProgSel  <= '0;
            io.CycleCt  <= '0;
            io.CtValid  <= 1'b0;
            io.TimedOut <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            wd_rst      <= 1'b0;
`endif
        end else begin
            io.CtValid <= 1'b0;
            case (state)
                IDLE: if (io.Go) begin
                    state       <= RST;
                    io.ProgSel  <= '0;
                    io.TimedOut <= 1'b0;
                end
                RST:   state <= START;
                START: if (tc) state <= RUN;
                RUN: begin
`ifdef SEQ_TIMEOUT_EN
                    if (wd_rst) begin
                        wd_rst <= 1'b0;
                        state  <= DONE;
                    end else
`endif
                    if (io.Ack) begin
                        io.CycleCt <= count;
                        io.CtValid <= 1'b1;
                        if (io.ProgSel == LAST_PROG) begin
                            state <= DONE;
                        end else begin
                            io.ProgSel <= io.ProgSel + PW'(1);
                            state      <= START;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (tc) begin
                        // Hung program: report the limit, reset the processor
                        // for one cycle and skip the remaining programs.
                        io.CycleCt  <= count;
                        io.CtValid  <= 1'b1;
                        io.TimedOut <= 1'b1;
                        wd_rst      <= 1'b1;
                    end
`endif
                end
                DONE:    if (!io.Go) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SEQ_TIMEOUT_EN
    assign wd_rst = 1'b0;
`endif

    assign io.DutReset = (state == IDLE) || (state == RST) || wd_rst;
    assign io.Start    = (state == START);
    assign io.Busy     = state inside {RST, START, RUN};
    assign io.AllDone  = (state == DONE);

endmodule
